controller: RTL and testbench
=============================

CONTROLLER -- requirements
Module: controller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning the width of the accumulator and memory word.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning the address width; depth is 2**ADDR_W words, 16 by default.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port code, input, 3 bits: the operation code, sampled every rising edge.
REQ-006 The block SHALL have port acc, output, DATA_W bits: the accumulator register.
REQ-007 The block SHALL have port addr, output, ADDR_W bits: the address register.
REQ-008 The block SHALL have port mem_q, output, DATA_W bits: combinational read of mem[addr].
REQ-009 The block SHALL have port halted, output, 1 bit: high while in state HALT.
REQ-010 The block SHALL have port op_cnt, output, 8 bits: count of executed non-NOP operations.

Function
REQ-011 The block SHALL contain an internal register-based memory of 2**ADDR_W words of DATA_W bits.
REQ-012 The block SHALL implement a two-state FSM with states RUN and HALT; RUN is entered on reset.
REQ-013 In RUN, the block SHALL decode code each rising edge with single-cycle latency; results are visible on outputs after that edge:
  - 0 NOP: no state change.
  - 1 INCA: addr <= addr+1, wrapping 2**ADDR_W-1 -> 0.
  - 2 DECA: addr <= addr-1, wrapping 0 -> 2**ADDR_W-1.
  - 3 LOAD: acc <= mem[addr].
  - 4 STORE: mem[addr] <= acc.
  - 5 INCACC: acc <= acc+1, modulo 2**DATA_W.
  - 6 ADD: acc <= acc + mem[addr], modulo 2**DATA_W, carry discarded.
  - 7 HALT: next state HALT.
REQ-014 ADD and LOAD SHALL use the memory contents and addr value from before the clock edge.
REQ-015 op_cnt SHALL increment on every executed code 1-7 in RUN, including HALT, and SHALL saturate at 255.
REQ-016 In HALT, the block SHALL ignore code, hold acc, addr, memory and op_cnt, and keep halted=1 until reset.
REQ-017 mem_q SHALL always equal mem[addr] combinationally, including during reset and HALT.
REQ-018 An X or unknown code SHALL NOT be decoded during reset; reset has priority over all operations.

Reset
REQ-019 While rst=0, acc SHALL be 0, addr SHALL be 0, op_cnt SHALL be 0, the state SHALL be RUN and halted SHALL be 0, all asynchronously.
REQ-020 On reset, each memory word mem[i] SHALL be initialised to the value i, zero-extended to DATA_W.
REQ-021 Reset asserted mid-operation, including in HALT, SHALL immediately restore every REQ-019/REQ-020 value, and the first edge after release SHALL execute code normally.

Verification
REQ-022 Scenario 1: reset, then apply codes 0,1,2,3,4,5,6,7, one per cycle -> addr goes 0,1,0,0,0,0,0,0; acc goes 0,0,0,0,0,1,1,1; halted=1 after code 7; op_cnt=7.
REQ-023 Scenario 2: from reset apply INCA x3 then LOAD -> addr=3, acc=3, mem_q=3.
REQ-024 Scenario 3: from reset apply DECA -> addr=15, mem_q=15; then INCA -> addr=0.
REQ-025 Scenario 4: from reset apply INCA x5 (addr=5), LOAD, ADD -> acc=10; then STORE -> mem_q=10.
REQ-026 Scenario 5: after HALT apply INCA and INCACC for 5 cycles -> acc, addr and op_cnt unchanged, halted=1; assert rst=0 -> halted=0, acc=0, addr=0, op_cnt=0.
REQ-027 Scenario 6: LOAD at addr=15 (acc=15), then INCACC repeated until acc=16'hFFFF, then one more INCACC -> acc=0, wrap-around with no other side effect.

Source files
------------

// File: rtl/controller.sv
// Accumulator/address controller over a small register-file memory.
// One opcode is decoded per clock in RUN; HALT freezes all state until reset.
module controller #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        code,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] mem_q,
    output logic              halted,
    output logic [7:0]        op_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_INCA   = 3'd1,
        OP_DECA   = 3'd2,
        OP_LOAD   = 3'd3,
        OP_STORE  = 3'd4,
        OP_INCACC = 3'd5,
        OP_ADD    = 3'd6,
        OP_HALT   = 3'd7
    } op_e;

    state_e                         state_q, state_d;
    logic [DATA_W-1:0]              acc_q, acc_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [7:0]                     op_cnt_q, op_cnt_d;
    logic [DEPTH-1:0][DATA_W-1:0]   mem_words_q, mem_words_d;
    logic [DATA_W-1:0]              rd_word;

    // Reads always see pre-edge contents, so LOAD/ADD use the old word.
    assign rd_word = mem_words_q[addr_q];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        addr_d      = addr_q;
        op_cnt_d    = op_cnt_q;
        mem_words_d = mem_words_q;
        if (state_q == RUN) begin
            unique case (op_e'(code))
                OP_NOP:    ;
                OP_INCA:   addr_d = addr_q + 1'b1;
                OP_DECA:   addr_d = addr_q - 1'b1;
                OP_LOAD:   acc_d  = rd_word;
                OP_STORE:  mem_words_d[addr_q] = acc_q;
                OP_INCACC: acc_d  = acc_q + 1'b1;
                OP_ADD:    acc_d  = acc_q + rd_word;
                OP_HALT:   state_d = HALT;
                default:   ;
            endcase
            if (code != OP_NOP && op_cnt_q != 8'hFF)
                op_cnt_d = op_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            acc_q    <= '0;
            addr_q   <= '0;
            op_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_words_q[i] <= DATA_W'(i);
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            addr_q      <= addr_d;
            op_cnt_q    <= op_cnt_d;
            mem_words_q <= mem_words_d;
        end
    end

    assign acc    = acc_q;
    assign addr   = addr_q;
    assign mem_q  = rd_word;
    assign halted = (state_q == HALT);
    assign op_cnt = op_cnt_q;

endmodule

// File: tb/tb_controller.sv
// Directed bench for controller: reset values, each opcode, wraps, HALT hold, saturation.
module tb_controller;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    logic              clk;
    logic              rst;
    logic [2:0]        code;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_q;
    logic              halted;
    logic [7:0]        op_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .code(code), .acc(acc), .addr(addr),
        .mem_q(mem_q), .halted(halted), .op_cnt(op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [2:0] c);
        @(negedge clk);
        code = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #2;
        rst  = 1'b0;
        code = 3'bxxx;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst  = 1'b1;
        code = 3'd0;
    endtask

    task automatic test_reset();
        code = 3'd0;
        rst  = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (acc !== 16'd0)  $display("FAIL reset_acc got %0d want 0", acc);  else n_pass++;
        n_chk++; if (addr !== 4'd0)  $display("FAIL reset_addr got %0d want 0", addr); else n_pass++;
        n_chk++; if (op_cnt !== 8'd0) $display("FAIL reset_opcnt got %0d want 0", op_cnt); else n_pass++;
        n_chk++; if (halted !== 1'b0) $display("FAIL reset_halted got %0b want 0", halted); else n_pass++;
        n_chk++; if (mem_q !== 16'd0) $display("FAIL reset_memq got %0d want 0", mem_q); else n_pass++;
        code = 3'd1;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_chk++; if (addr !== 4'd0) $display("FAIL reset_priority_addr got %0d want 0", addr); else n_pass++;
        @(negedge clk);
        rst  = 1'b1;
        code = 3'd0;
    endtask

    task automatic test_all_codes();
        logic [3:0]  exp_addr [8] = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
        logic [15:0] exp_acc  [8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            step(3'(i));
            n_chk++; if (addr !== exp_addr[i]) $display("FAIL seq_addr code%0d got %0d want %0d", i, addr, exp_addr[i]); else n_pass++;
            n_chk++; if (acc !== exp_acc[i])   $display("FAIL seq_acc code%0d got %0d want %0d", i, acc, exp_acc[i]);   else n_pass++;
        end
        n_chk++; if (halted !== 1'b1) $display("FAIL seq_halted got %0b want 1", halted); else n_pass++;
        n_chk++; if (op_cnt !== 8'd7) $display("FAIL seq_opcnt got %0d want 7", op_cnt); else n_pass++;
    endtask

    task automatic test_load();
        apply_reset();
        for (int i = 0; i < 3; i++) step(3'd1);
        step(3'd3);
        n_chk++; if (addr !== 4'd3)   $display("FAIL load_addr got %0d want 3", addr); else n_pass++;
        n_chk++; if (acc !== 16'd3)   $display("FAIL load_acc got %0d want 3", acc);   else n_pass++;
        n_chk++; if (mem_q !== 16'd3) $display("FAIL load_memq got %0d want 3", mem_q); else n_pass++;
        n_chk++; if (op_cnt !== 8'd4) $display("FAIL load_opcnt got %0d want 4", op_cnt); else n_pass++;
    endtask

    task automatic test_addr_wrap();
        apply_reset();
        step(3'd2);
        n_chk++; if (addr !== 4'd15)   $display("FAIL deca_wrap_addr got %0d want 15", addr); else n_pass++;
        n_chk++; if (mem_q !== 16'd15) $display("FAIL deca_wrap_memq got %0d want 15", mem_q); else n_pass++;
        step(3'd1);
        n_chk++; if (addr !== 4'd0)    $display("FAIL inca_wrap_addr got %0d want 0", addr); else n_pass++;
    endtask

    task automatic test_add_store();
        apply_reset();
        for (int i = 0; i < 5; i++) step(3'd1);
        step(3'd3);
        step(3'd6);
        n_chk++; if (acc !== 16'd10)   $display("FAIL add_acc got %0d want 10", acc); else n_pass++;
        n_chk++; if (mem_q !== 16'd5)  $display("FAIL add_memq_pre got %0d want 5", mem_q); else n_pass++;
        step(3'd4);
        n_chk++; if (mem_q !== 16'd10) $display("FAIL store_memq got %0d want 10", mem_q); else n_pass++;
        n_chk++; if (acc !== 16'd10)   $display("FAIL store_acc got %0d want 10", acc); else n_pass++;
    endtask

    task automatic test_halt_hold();
        // Continues from test_add_store: addr=5, acc=10, mem[5]=10, op_cnt=8.
        step(3'd7);
        n_chk++; if (halted !== 1'b1) $display("FAIL halt_enter got %0b want 1", halted); else n_pass++;
        n_chk++; if (op_cnt !== 8'd9) $display("FAIL halt_opcnt got %0d want 9", op_cnt); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(3'd1);
            step(3'd5);
            step(3'd4);
        end
        n_chk++; if (acc !== 16'd10)  $display("FAIL halt_hold_acc got %0d want 10", acc);  else n_pass++;
        n_chk++; if (addr !== 4'd5)   $display("FAIL halt_hold_addr got %0d want 5", addr); else n_pass++;
        n_chk++; if (op_cnt !== 8'd9) $display("FAIL halt_hold_opcnt got %0d want 9", op_cnt); else n_pass++;
        n_chk++; if (halted !== 1'b1) $display("FAIL halt_hold_halted got %0b want 1", halted); else n_pass++;
        n_chk++; if (mem_q !== 16'd10) $display("FAIL halt_hold_memq got %0d want 10", mem_q); else n_pass++;
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0) $display("FAIL halt_reset_halted got %0b want 0", halted); else n_pass++;
        n_chk++; if (acc !== 16'd0)   $display("FAIL halt_reset_acc got %0d want 0", acc);   else n_pass++;
        n_chk++; if (addr !== 4'd0)   $display("FAIL halt_reset_addr got %0d want 0", addr); else n_pass++;
        n_chk++; if (op_cnt !== 8'd0) $display("FAIL halt_reset_opcnt got %0d want 0", op_cnt); else n_pass++;
        @(negedge clk);
        rst  = 1'b1;
        code = 3'd0;
        // Memory word 5 must be back to its reset value.
        for (int i = 0; i < 5; i++) step(3'd1);
        n_chk++; if (mem_q !== 16'd5) $display("FAIL halt_reset_mem5 got %0d want 5", mem_q); else n_pass++;
    endtask

    task automatic test_acc_wrap();
        apply_reset();
        step(3'd2);
        step(3'd3);
        n_chk++; if (acc !== 16'd15) $display("FAIL wrap_load_acc got %0d want 15", acc); else n_pass++;
        for (int i = 0; i < 65520; i++) step(3'd5);
        n_chk++; if (acc !== 16'hFFFF) $display("FAIL wrap_max_acc got %0h want ffff", acc); else n_pass++;
        step(3'd5);
        n_chk++; if (acc !== 16'd0)     $display("FAIL wrap_acc got %0d want 0", acc); else n_pass++;
        n_chk++; if (addr !== 4'd15)    $display("FAIL wrap_addr got %0d want 15", addr); else n_pass++;
        n_chk++; if (mem_q !== 16'd15)  $display("FAIL wrap_memq got %0d want 15", mem_q); else n_pass++;
        n_chk++; if (halted !== 1'b0)   $display("FAIL wrap_halted got %0b want 0", halted); else n_pass++;
        n_chk++; if (op_cnt !== 8'd255) $display("FAIL opcnt_saturate got %0d want 255", op_cnt); else n_pass++;
    endtask

    initial begin
        rst  = 1'b1;
        code = 3'd0;
        test_reset();
        test_all_codes();
        test_load();
        test_addr_wrap();
        test_add_store();
        test_halt_hold();
        test_acc_wrap();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
